// File: rtl/tdm_mux_nx1.sv
// tdm_mux_nx1: serialises 2**n parallel lanes into one TDM stream, LSB lane first.
// Define TDM_MUX_PARITY_EN to append an even-parity slot to every frame.
module tdm_mux_nx1 #(
    parameter int n = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            restart,
    input  logic [2**n-1:0] d,
    output logic            y,
    output logic [n-1:0]    s,
    output logic            valid,
    output logic            frame_start,
    output logic            par_slot
);
    localparam int lanes = 2**n;
`ifdef TDM_MUX_PARITY_EN
    localparam logic [n:0] last = (n+1)'(lanes);
`else
    localparam logic [n:0] last = (n+1)'(lanes - 1);
`endif
    logic [n:0]       cnt, k;
    logic [lanes-1:0] snap;
    logic [n-1:0]     lane;
    logic             par;
    // restart makes the current edge behave as slot 0
    assign k    = restart ? '0 : cnt;
    assign lane = k[n-1:0];
`ifdef TDM_MUX_PARITY_EN
    assign par  = k[n];
`else
    assign par  = 1'b0;
    assign par_slot = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            y           <= 1'b0;
            s           <= '0;
            valid       <= 1'b0;
            frame_start <= 1'b0;
            cnt         <= '0;
            snap        <= '0;
`ifdef TDM_MUX_PARITY_EN
            par_slot    <= 1'b0;
`endif
        end else if (en) begin
            if (k == '0) snap <= d;
            y           <= (k == '0) ? d[0] : par ? ^snap : snap[lane];
            s           <= par ? '1 : lane;
            valid       <= 1'b1;
            frame_start <= (k == '0);
            cnt         <= (k == last) ? '0 : k + 1'b1;
`ifdef TDM_MUX_PARITY_EN
            par_slot    <= par;
`endif
        end else begin
            y           <= 1'b0;
            valid       <= 1'b0;
            frame_start <= 1'b0;
            if (restart) cnt <= '0;
`ifdef TDM_MUX_PARITY_EN
            par_slot    <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_tdm_mux_nx1.sv
// tb_tdm_mux_nx1: directed self-checking bench for tdm_mux_nx1 with n=3.
module tb_tdm_mux_nx1;
    logic       clk = 1'b0;
    logic       rst = 1'b0, en = 1'b0, restart = 1'b0;
    logic [7:0] d = '0;
    logic       y, valid, frame_start, par_slot;
    logic [2:0] s;
    int checks = 0, failures = 0;

    tdm_mux_nx1 #(.n(3)) dut (
        .clk(clk), .rst(rst), .en(en), .restart(restart), .d(d),
        .y(y), .s(s), .valid(valid), .frame_start(frame_start), .par_slot(par_slot)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; restart = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic parity_gap();
`ifdef TDM_MUX_PARITY_EN
        step();
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; restart = 1'b1; d = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({y, s, valid, frame_start, par_slot} !== 7'b0) begin
                failures++;
                $display("FAIL reset cyc%0d got=%b exp=%b", i, {y, s, valid, frame_start, par_slot}, 7'b0);
            end
        end
        rst = 1'b0; en = 1'b0; restart = 1'b0;
    endtask

    task automatic test_frame();
        logic [7:0] v = 8'hA6;
        en = 1'b1; d = v;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if ({y, s, valid, frame_start, par_slot} !== {v[i], 3'(i), 1'b1, i == 0, 1'b0}) begin
                failures++;
                $display("FAIL frame slot%0d got=%b exp=%b", i, {y, s, valid, frame_start, par_slot}, {v[i], 3'(i), 1'b1, i == 0, 1'b0});
            end
        end
        en = 1'b0;
    endtask

    task automatic test_snapshot();
        logic [7:0] v = 8'hA6;
        do_reset();
        en = 1'b1; d = v;
        for (int i = 0; i < 8; i++) begin
            step();
            d = 8'hFF;
            checks++;
            if ({y, s, valid, frame_start} !== {v[i], 3'(i), 1'b1, i == 0}) begin
                failures++;
                $display("FAIL snapshot slot%0d got=%b exp=%b", i, {y, s, valid, frame_start}, {v[i], 3'(i), 1'b1, i == 0});
            end
        end
        parity_gap();
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if ({y, s, valid, frame_start} !== {1'b1, 3'(i), 1'b1, i == 0}) begin
                failures++;
                $display("FAIL ones_frame slot%0d got=%b exp=%b", i, {y, s, valid, frame_start}, {1'b1, 3'(i), 1'b1, i == 0});
            end
        end
        en = 1'b0;
    endtask

    task automatic test_hold();
        logic [7:0] v = 8'hA6;
        do_reset();
        en = 1'b1; d = v;
        for (int i = 0; i < 4; i++) step();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({y, s, valid, frame_start} !== {1'b0, 3'd3, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL hold cyc%0d got=%b exp=%b", i, {y, s, valid, frame_start}, {1'b0, 3'd3, 1'b0, 1'b0});
            end
        end
        en = 1'b1; d = 8'hFF;
        for (int i = 4; i < 8; i++) begin
            step();
            checks++;
            if ({y, s, valid, frame_start} !== {v[i], 3'(i), 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL resume slot%0d got=%b exp=%b", i, {y, s, valid, frame_start}, {v[i], 3'(i), 1'b1, 1'b0});
            end
        end
        en = 1'b0;
    endtask

    task automatic test_restart_reset();
        logic [7:0] v = 8'h5B;
        do_reset();
        en = 1'b1; d = 8'hA6;
        for (int i = 0; i < 6; i++) step();
        restart = 1'b1; d = v;
        for (int i = 0; i < 6; i++) begin
            step();
            restart = 1'b0; d = 8'h00;
            checks++;
            if ({y, s, valid, frame_start} !== {v[i], 3'(i), 1'b1, i == 0}) begin
                failures++;
                $display("FAIL restart slot%0d got=%b exp=%b", i, {y, s, valid, frame_start}, {v[i], 3'(i), 1'b1, i == 0});
            end
        end
        rst = 1'b1; restart = 1'b1;
        step();
        rst = 1'b0; restart = 1'b0;
        checks++;
        if ({y, s, valid, frame_start, par_slot} !== 7'b0) begin
            failures++;
            $display("FAIL midframe_rst got=%b exp=%b", {y, s, valid, frame_start, par_slot}, 7'b0);
        end
        d = 8'h81;
        step();
        checks++;
        if ({y, s, valid, frame_start} !== {1'b1, 3'd0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL after_rst got=%b exp=%b", {y, s, valid, frame_start}, {1'b1, 3'd0, 1'b1, 1'b1});
        end
        step(); step();
        en = 1'b0; restart = 1'b1;
        step();
        restart = 1'b0;
        checks++;
        if ({y, s, valid, frame_start} !== {1'b0, 3'd2, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL idle_restart got=%b exp=%b", {y, s, valid, frame_start}, {1'b0, 3'd2, 1'b0, 1'b0});
        end
        en = 1'b1; d = 8'h00;
        step();
        checks++;
        if ({y, s, valid, frame_start} !== {1'b0, 3'd0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL idle_restart_resume got=%b exp=%b", {y, s, valid, frame_start}, {1'b0, 3'd0, 1'b1, 1'b1});
        end
        en = 1'b0;
    endtask

`ifdef TDM_MUX_PARITY_EN
    task automatic test_parity();
        logic [7:0] v [2] = '{8'hA6, 8'h07};
        logic       p [2] = '{1'b0, 1'b1};
        do_reset();
        en = 1'b1;
        for (int f = 0; f < 2; f++) begin
            d = v[f];
            for (int i = 0; i < 9; i++) begin
                step();
                if (i == 0) begin
                    checks++;
                    if (frame_start !== 1'b1) begin
                        failures++;
                        $display("FAIL parity_fs frame%0d got=%b exp=1", f, frame_start);
                    end
                end
            end
            checks++;
            if ({y, s, valid, frame_start, par_slot} !== {p[f], 3'd7, 1'b1, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL parity_slot frame%0d got=%b exp=%b", f, {y, s, valid, frame_start, par_slot}, {p[f], 3'd7, 1'b1, 1'b0, 1'b1});
            end
        end
        step();
        checks++;
        if ({s, frame_start, par_slot} !== {3'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL parity_wrap got=%b exp=%b", {s, frame_start, par_slot}, {3'd0, 1'b1, 1'b0});
        end
        en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_snapshot();
        test_hold();
        test_restart_reset();
`ifdef TDM_MUX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
